// File: rtl/irq_pend8_if.sv
// Bus bundle between the irq_pend8 capture stage and its consumer.
// Optional overflow signals are present only when IRQ_PEND8_OVF_EN is defined.
interface irq_pend8_if;
  logic [7:0] irq_in;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic       irq_ack;
  logic [7:0] pend_d;
  logic       irq_valid;
  logic [2:0] irq_id;
  logic [7:0] mask;
`ifdef IRQ_PEND8_OVF_EN
  logic [7:0] ovf;
  logic       ovf_clr;
`endif

  modport master (
    output irq_in, mask_we, mask_wdata, irq_ack,
`ifdef IRQ_PEND8_OVF_EN
    output ovf_clr,
    input  ovf,
`endif
    input  pend_d, irq_valid, irq_id, mask
  );

  modport slave (
    input  irq_in, mask_we, mask_wdata, irq_ack,
`ifdef IRQ_PEND8_OVF_EN
    input  ovf_clr,
    output ovf,
`endif
    output pend_d, irq_valid, irq_id, mask
  );
endinterface

// File: rtl/irq_pend8.sv
// Eight-line interrupt capture: sync, pending latch, mask, and held-index valid/ack presentation.
// Define IRQ_PEND8_OVF_EN to add sticky per-line overflow flags (ovf / ovf_clr).
module irq_pend8 #(
  parameter int unsigned EDGE_MODE = 1
) (
  input logic        clk,
  input logic        rst_n,
  irq_pend8_if.slave bus
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t     state, state_nxt;
  logic [7:0] s1, s2, s3;
  logic [7:0] set, clr;
  logic [7:0] pending, mask_q, pend_d;
  logic [2:0] id_q, id_nxt, top_id;
  logic       ack_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= bus.irq_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  generate
    if (EDGE_MODE != 0) begin : g_edge
      assign set = s2 & ~s3;
    end else begin : g_level
      assign set = s2;
    end
  endgenerate

  assign ack_fire = (state == PRESENT) && bus.irq_ack;

  always_comb begin
    clr = '0;
    if (ack_fire) clr[id_q] = 1'b1;
  end

  // Set is OR-ed after the clear so a same-cycle set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      mask_q  <= '1;
    end else begin
      pending <= (pending & ~clr) | set;
      if (bus.mask_we) mask_q <= bus.mask_wdata;
    end
  end

  assign pend_d        = pending & ~mask_q;
  assign bus.pend_d    = pend_d;
  assign bus.mask      = mask_q;
  assign bus.irq_valid = (state == PRESENT);
  assign bus.irq_id    = id_q;

  always_comb begin
    top_id = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (pend_d[i]) top_id = 3'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      id_q  <= '0;
    end else begin
      state <= state_nxt;
      id_q  <= id_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    id_nxt    = id_q;
    unique case (state)
      IDLE: begin
        if (pend_d != '0) begin
          id_nxt    = top_id;
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (bus.irq_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef IRQ_PEND8_OVF_EN
  logic [7:0] ovf_q;

  generate
    if (EDGE_MODE != 0) begin : g_ovf
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= '0;
        else        ovf_q <= (bus.ovf_clr ? '0 : ovf_q) | (set & pending & ~clr);
      end
    end else begin : g_no_ovf
      assign ovf_q = '0;
    end
  endgenerate

  assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_irq_pend8.sv
// Self-checking bench for irq_pend8: directed stimulus with a scoreboard of expected presented ids.
// Exercises the overflow flags when IRQ_PEND8_OVF_EN is defined.
module tb_irq_pend8;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic prev_valid;
  logic [2:0] exp_q[$];

  irq_pend8_if bus ();

  irq_pend8 #(.EDGE_MODE(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_mask(input logic [7:0] m);
    bus.mask_we    = 1'b1;
    bus.mask_wdata = m;
    tick();
    bus.mask_we    = 1'b0;
  endtask

  // Hold irq_in for three edges so it reaches pending, then release.
  task automatic pulse(input logic [7:0] v);
    bus.irq_in = v;
    repeat (3) tick();
    bus.irq_in = '0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!bus.irq_valid && n < 20) begin
      tick();
      n++;
    end
    if (!bus.irq_valid) check(tag, 32'(bus.irq_valid), 32'd1);
  endtask

  task automatic ack();
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
  endtask

  // Scoreboard: each new presentation pops the next expected id.
  always @(posedge clk) begin
    #1;
    if (bus.irq_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected", 32'(bus.irq_id), 32'hFFFF_FFFF);
      end else begin
        check("sb_id", 32'(bus.irq_id), 32'(exp_q.pop_front()));
      end
    end
    prev_valid = bus.irq_valid;
  end

  initial begin
    checks = 0;
    failures = 0;
    prev_valid = 1'b0;
    rst_n = 1'b0;
    bus.irq_in = '0;
    bus.mask_we = 1'b0;
    bus.mask_wdata = '0;
    bus.irq_ack = 1'b0;
`ifdef IRQ_PEND8_OVF_EN
    bus.ovf_clr = 1'b0;
`endif
    repeat (2) tick();
    check("rst_pend_d", 32'(bus.pend_d), 32'h00);
    check("rst_valid", 32'(bus.irq_valid), 32'd0);
    check("rst_id", 32'(bus.irq_id), 32'd0);
    check("rst_mask", 32'(bus.mask), 32'hFF);
    rst_n = 1'b1;
    tick();

    write_mask(8'h00);
    check("mask_wr", 32'(bus.mask), 32'h00);

    // Single line 0: pending after N+2, presentation after N+3.
    exp_q.push_back(3'd0);
    bus.irq_in = 8'h01;
    repeat (3) tick();
    check("l0_pend_d", 32'(bus.pend_d), 32'h01);
    check("l0_valid_early", 32'(bus.irq_valid), 32'd0);
    bus.irq_in = '0;
    tick();
    check("l0_valid", 32'(bus.irq_valid), 32'd1);
    check("l0_id", 32'(bus.irq_id), 32'd0);
    ack();
    check("l0_ack_pend_d", 32'(bus.pend_d), 32'h00);
    check("l0_ack_valid", 32'(bus.irq_valid), 32'd0);

    // Lines 4 and 0 together: 4 first, then 0 after a one-cycle gap.
    exp_q.push_back(3'd4);
    exp_q.push_back(3'd0);
    pulse(8'h11);
    wait_valid("p11_timeout");
    check("p11_id4", 32'(bus.irq_id), 32'd4);
    ack();
    check("p11_gap", 32'(bus.irq_valid), 32'd0);
    check("p11_pend_d", 32'(bus.pend_d), 32'h01);
    tick();
    check("p11_valid0", 32'(bus.irq_valid), 32'd1);
    check("p11_id0", 32'(bus.irq_id), 32'd0);
    ack();

    // Masked line still latches; unmasking presents it.
    write_mask(8'h80);
    pulse(8'h80);
    repeat (4) tick();
    check("m80_pend_d", 32'(bus.pend_d), 32'h00);
    check("m80_valid", 32'(bus.irq_valid), 32'd0);
    exp_q.push_back(3'd7);
    write_mask(8'h00);
    check("m80_unmask_pend_d", 32'(bus.pend_d), 32'h80);
    wait_valid("m80_timeout");
    check("m80_id", 32'(bus.irq_id), 32'd7);
    ack();

    // Held id: higher line arriving during presentation does not preempt.
    exp_q.push_back(3'd2);
    exp_q.push_back(3'd6);
    pulse(8'h04);
    wait_valid("hold_timeout");
    pulse(8'h40);
    repeat (3) tick();
    check("hold_id", 32'(bus.irq_id), 32'd2);
    check("hold_valid", 32'(bus.irq_valid), 32'd1);
    check("hold_pend_d", 32'(bus.pend_d), 32'h44);
    ack();
    check("hold_gap", 32'(bus.irq_valid), 32'd0);
    wait_valid("hold6_timeout");
    check("hold_id6", 32'(bus.irq_id), 32'd6);
    ack();

    // Async reset mid-handshake.
    exp_q.push_back(3'd3);
    pulse(8'h08);
    wait_valid("rst_mid_timeout");
    rst_n = 1'b0;
    #1;
    check("rmid_valid", 32'(bus.irq_valid), 32'd0);
    check("rmid_mask", 32'(bus.mask), 32'hFF);
    check("rmid_id", 32'(bus.irq_id), 32'd0);
    tick();
    rst_n = 1'b1;
    ack();
    check("rmid_ack_valid", 32'(bus.irq_valid), 32'd0);
    write_mask(8'h00);
    check("rmid_pending", 32'(bus.pend_d), 32'h00);
    repeat (3) tick();
    check("rmid_idle", 32'(bus.irq_valid), 32'd0);

`ifdef IRQ_PEND8_OVF_EN
    exp_q.push_back(3'd3);
    pulse(8'h08);
    tick();
    pulse(8'h08);
    repeat (2) tick();
    check("ovf_set", 32'(bus.ovf), 32'h08);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    check("ovf_clr", 32'(bus.ovf), 32'h00);
    wait_valid("ovf_timeout");
    check("ovf_id", 32'(bus.irq_id), 32'd3);
    ack();
    check("ovf_ack_pend_d", 32'(bus.pend_d), 32'h00);
`endif

    repeat (4) tick();
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
